// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer with a registered interrupt request.
// The register window is CTRL, PRESET and COUNT at BASE_ADDR, +4 and +8.
// Read data is combinational from addr. Writes take effect only on full-word stores.
// Optional feature: define BUS_TIMER_PRESCALER_EN to add a read/write PRESC field in CTRL[7:4].
// With PRESC set, COUNT steps once every 2^PRESC cycles.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL    = 2'b00;
    localparam logic [1:0] SEL_PRESET  = 2'b01;
    localparam logic [1:0] SEL_COUNT   = 2'b10;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic        r_flag;
    logic        r_irq;
    logic [31:0] r_preset;
    logic [31:0] r_count;

    logic        w_hit;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_tick;
    logic        w_load;
    logic        w_en_clear;
    logic        w_flag_next;
    logic        w_im_next;
    logic [31:0] w_count_next;
    logic [3:0]  w_presc_rd;
    logic [31:0] w_ctrl_rd;
    logic        w_unused_ok;

    // Address decode: the slot at offset 0xc inside the window is not a register.
    assign w_hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign w_wr        = w_hit && (byteen == 4'b1111);
    assign w_wr_ctrl   = w_wr && (addr[3:2] == SEL_CTRL);
    assign w_wr_preset = w_wr && (addr[3:2] == SEL_PRESET);
    assign w_im_next   = w_wr_ctrl ? wdata[3] : r_im;

`ifdef BUS_TIMER_PRESCALER_EN
    logic [3:0]  r_presc;
    logic [15:0] r_presc_cnt;
    logic [15:0] w_presc_mask;

    // A tick occurs when the low PRESC bits of the prescale counter are all ones.
    assign w_presc_mask = ~(16'hFFFF << r_presc);
    assign w_tick       = (r_presc_cnt & w_presc_mask) == w_presc_mask;
    assign w_presc_rd   = r_presc;
    assign w_unused_ok  = &{1'b0, addr[1:0], wdata[31:8]};

    // PRESC field of CTRL, software-written only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= 4'd0;
        end else if (w_wr_ctrl) begin
            r_presc <= wdata[7:4];
        end
    end

    // Free-running prescale counter, restarted on every LOAD so each period starts aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc_cnt <= 16'd0;
        end else if (w_load) begin
            r_presc_cnt <= 16'd0;
        end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
        end
    end
`else
    assign w_tick      = 1'b1;
    assign w_presc_rd  = 4'd0;
    assign w_unused_ok = &{1'b0, addr[1:0], wdata[31:4]};
`endif

    assign w_ctrl_rd = {24'd0, w_presc_rd, r_im, r_mode, r_en};

    // Combinational read mux; misses and offset 0xc return zero
    always_comb begin
        rdata = 32'd0;
        if (w_hit) begin
            case (addr[3:2])
                SEL_CTRL:   rdata = w_ctrl_rd;
                SEL_PRESET: rdata = r_preset;
                SEL_COUNT:  rdata = r_count;
                default:    rdata = 32'd0;
            endcase
        end
    end

    // Next-state, next-count and flag logic of the countdown FSM
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_count_next = r_count;
        w_flag_next  = r_flag;
        w_en_clear   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_count_next = r_preset;
                w_state_next = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_next = S_IDLE;
                end else if (w_tick) begin
                    if (r_count > 32'd1) begin
                        w_count_next = r_count - 32'd1;
                    end else begin
                        w_count_next = 32'd0;
                        w_flag_next  = 1'b1;
                        w_state_next = S_INT;
                    end
                end
            end
            S_INT: begin
                w_state_next = S_IDLE;
                if (r_mode == MODE_RELOAD) begin
                    w_flag_next = 1'b0;
                end else begin
                    w_en_clear = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Software writing CTRL or PRESET acknowledges the interrupt.
        if (w_wr_ctrl || w_wr_preset) begin
            w_flag_next = 1'b0;
        end
    end

    // FSM state, COUNT, flag and the registered irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
            r_flag  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_flag  <= w_flag_next;
            r_irq   <= w_flag_next & w_im_next;
        end
    end

    // CTRL EN/MODE/IM: a software write wins over the one-shot hardware EN clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_mode <= 2'b00;
            r_im   <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en   <= wdata[0];
            r_mode <= wdata[2:1];
            r_im   <= wdata[3];
        end else if (w_en_clear) begin
            r_en   <= 1'b0;
        end
    end

    // PRESET register; changes only take effect at the next LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            r_preset <= wdata;
        end
    end

    assign irq = r_irq;

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped countdown timer that answers the CPU's data-memory port and drives one bit of the core's `HWInt` vector. It decodes a 12-byte register window (CTRL, PRESET, COUNT) at `BASE_ADDR`, accepts word writes from the store path, and returns read data combinationally so the CPU's M stage can sample it in the same cycle. It counts down from PRESET and raises an interrupt request when the count expires, in one-shot or auto-reload mode.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h0000_7f00. Byte address of CTRL; PRESET is at +4, COUNT at +8. Must be 16-byte aligned.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  32  byte address from the CPU (`m_data_addr`).
- `byteen`  in  4  write byte enables from the CPU (`m_data_byteen`); 4'b0000 means no write.
- `wdata`  in  32  write data (`m_data_wdata`).
- `rdata`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request to one `HWInt` bit; registered.

## Operation

- Hit: `addr[31:4] == BASE_ADDR[31:4]` and `addr[3:2] != 2'b11`. Register select is `addr[3:2]` (00 CTRL, 01 PRESET, 10 COUNT). `addr[1:0]` is ignored.
- Write: performed on a hit when `byteen == 4'b1111`. Any other non-zero `byteen` is ignored; the CPU already traps sub-word stores to this window.
- CTRL[0] EN: counter enable.
- CTRL[2:1] MODE: 00 one-shot, 01 auto-reload; 1x is treated as 00.
- CTRL[3] IM: interrupt mask.
- CTRL[31:4]: reads 0, except the bits defined under Configuration.
- PRESET[31:0]: read/write.
- COUNT: read-only; writes to it are ignored.
- Read: `rdata` returns the selected register. It returns 0 on a miss or at offset 0xc.
- Internal `flag`: set on expiry. `irq = flag & CTRL[3]`, registered together with `flag`.
- A write to CTRL or PRESET clears `flag` on the same edge.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Otherwise, if COUNT > 1, COUNT <= COUNT-1 and stay. Otherwise (COUNT ≤ 1), COUNT <= 0, flag <= 1, go to INT.
  - INT, MODE 00: EN <= 0, go to IDLE. `flag` stays set until software writes CTRL or PRESET.
  - INT, MODE 01: flag <= 0, go to IDLE. EN stays set, so the timer reloads. `flag` is therefore high for exactly one cycle per period.
- Boundary rules:
  - PRESET of 0 or 1: expires on the first CNT edge.
  - PRESET written while counting: no effect until the next LOAD.
  - CTRL write during INT: the written value wins over the hardware EN clear and the flag changes. The FSM still goes to IDLE.
  - Counting is 32-bit unsigned with no wrap; the decrement is never applied at 0.

## Timing

- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, flag=0, `irq`=0. `rdata` follows `addr` (0 for CTRL, PRESET and COUNT).
- Write latency: the register updates on the edge at which the write is presented. A read in the next cycle returns the new value.
- EN written at edge E0 gives: IDLE→LOAD at E1, COUNT=PRESET at E2, then one decrement per edge from E3.
- For PRESET=N≥1, `flag` is set at edge E(N+2). With IM=1, `irq` is visible in the cycle after E(N+2).
- Auto-reload period: N+3 cycles between `irq` pulses (CNT edges, INT, IDLE, LOAD).
- Asynchronous reset mid-count: everything returns to reset values immediately. `irq` drops without waiting for a clock edge.

## Configuration

- `BUS_TIMER_PRESCALER_EN` defined:
  - CTRL[7:4] is PRESC, read/write, reset 0.
  - In CNT, COUNT moves only when a free-running 16-bit prescale counter has its low PRESC bits all 1, i.e. once every 2^PRESC cycles. This applies to both the decrement and the expiry check.
  - The prescale counter resets to 0 on reset and on every LOAD.
- `BUS_TIMER_PRESCALER_EN` undefined:
  - CTRL[7:4] reads 0 and writes to it are ignored.
  - COUNT moves every cycle in CNT, with timing exactly as above.

## Test plan

- Reset then read: read at 0x7f00, 0x7f04, 0x7f08 → 0 each; `irq`=0; read at 0x7f0c and 0x7f20 → 0.
- One-shot: PRESET=5, then CTRL=0x9 → COUNT reads 5,4,3,2,1,0; `irq` rises 7 edges after the CTRL write and stays high; CTRL reads 0x8 (EN cleared). A write of CTRL=0 drops `irq` the next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → one-cycle `irq` pulses every 6 cycles; EN stays 1.
- Mask and ignored writes: PRESET=2, CTRL=0x1 → COUNT reaches 0 and `irq` stays 0. A write of 0xFFFF to COUNT and a write with `byteen`=4'b0011 to PRESET leave both registers unchanged.
- Mid-operation: PRESET=100, CTRL=0x9; write PRESET=2 while COUNT=50 → countdown continues from 50. Assert `reset` at COUNT=20 → all registers 0 at once, `irq`=0, no interrupt afterwards.
- With `BUS_TIMER_PRESCALER_EN`: PRESET=2, CTRL=0x29 (PRESC=2) → COUNT steps every 4 cycles. Without the macro, CTRL reads back 0x09.
